i2s_tx: RTL and testbench

Serial audio transmitter that sits directly downstream of `effects_pipline` and drives the output codec. It accepts processed 16-bit mono samples through a valid/ready handshake and buffers them in a 2-entry FIFO. It generates the bit clock (`bclk`) and word-select (`lrclk`) from `clk`, and shifts each sample out MSB-first in standard I2S format on both the left and right slots.

---
 rtl/i2s_tx_if.sv | 12 +
 rtl/i2s_tx.sv | 110 +++++++++++
 tb/tb_i2s_tx.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_if.sv
// Sample handshake between the effects pipeline and the I2S transmitter.
// The master drives sample/sample_vld; the transmitter answers with sample_rdy.
interface i2s_tx_if #(
   parameter int unsigned SLEN = 16
);
   logic [SLEN-1:0] sample;
   logic            sample_vld;
   logic            sample_rdy;

   modport master (output sample, output sample_vld, input sample_rdy);
   modport slave  (input sample, input sample_vld, output sample_rdy);
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: 2-entry sample FIFO, bclk/lrclk generation from clk, and
// MSB-first serialisation of each mono sample onto both left and right slots.
module i2s_tx #(
   parameter int unsigned SLEN    = 16,
   parameter int unsigned CLK_DIV = 4
) (
   input  logic    clk,
   input  logic    rst_n,
   i2s_tx_if.slave bus,
   output logic    bclk,
   output logic    lrclk,
   output logic    sdata,
   output logic    underrun
);
   localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned NSLOT  = 2 * SLEN;
   localparam int unsigned SLOT_W = $clog2(NSLOT);
   localparam int unsigned FRM_W  = 2 * SLEN;

   logic [DIV_W-1:0]  div_cnt;
   logic [SLOT_W-1:0] slot;
   logic [FRM_W-1:0]  shreg;
   logic [SLEN-1:0]   mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;

   logic              div_tick_c;
   logic              fall_c;
   logic              load_c;
   logic              push_c;
   logic              pop_c;
   logic              empty_c;
   logic              full_c;
   logic              lr_nxt_c;
   logic [SLOT_W-1:0] slot_nxt_c;
   logic [FRM_W-1:0]  frame_c;

   // Event decode: divider tick, bclk falling event, frame load and FIFO strobes
   always_comb begin
      empty_c    = (count == 2'd0);
      full_c     = (count == 2'd2);
      div_tick_c = (div_cnt == DIV_W'(CLK_DIV - 1));
      fall_c     = div_tick_c && bclk;
      load_c     = fall_c && (slot == SLOT_W'(NSLOT - 1));
      push_c     = bus.sample_vld && !full_c;
      pop_c      = load_c && !empty_c;
      slot_nxt_c = load_c ? '0 : slot + SLOT_W'(1);
      frame_c    = empty_c ? '0 : {mem[rd_ptr], mem[rd_ptr]};
      // lrclk leads each channel's MSB by one slot
      lr_nxt_c   = (slot_nxt_c >= SLOT_W'(SLEN - 1)) && (slot_nxt_c <= SLOT_W'(NSLOT - 2));
   end

   assign bus.sample_rdy = !full_c;

   // Bit-clock divider
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else begin
         div_cnt <= div_tick_c ? '0 : div_cnt + DIV_W'(1);
         bclk    <= bclk ^ div_tick_c;
      end
   end

   // Slot counter, word select and serialiser, all advanced on bclk falling events
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot     <= SLOT_W'(NSLOT - 1);
         shreg    <= '0;
         lrclk    <= 1'b0;
         sdata    <= 1'b0;
         underrun <= 1'b0;
      end else begin
         underrun <= load_c && empty_c;
         if (fall_c) begin
            slot  <= slot_nxt_c;
            lrclk <= lr_nxt_c;
            if (load_c) begin
               sdata <= frame_c[FRM_W-1];
               shreg <= {frame_c[FRM_W-2:0], 1'b0};
            end else begin
               sdata <= shreg[FRM_W-1];
               shreg <= {shreg[FRM_W-2:0], 1'b0};
            end
         end
      end
   end

   // Two-entry FIFO; simultaneous push and pop leave the count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else begin
         if (push_c) begin
            mem[wr_ptr] <= bus.sample;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_c) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + 2'(push_c) - 2'(pop_c);
      end
   end
endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: randomized and directed stimulus checked every clk against
// a reference model derived from edge-count arithmetic and a sample queue.
module tb_i2s_tx;
   localparam int SLEN    = 16;
   localparam int CLK_DIV = 4;
   localparam int BITP    = 2 * CLK_DIV;
   localparam int FRAME   = 2 * SLEN * BITP;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic bclk, lrclk, sdata, underrun;

   i2s_tx_if #(.SLEN(SLEN)) bus ();

   i2s_tx #(.SLEN(SLEN), .CLK_DIV(CLK_DIV)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .bclk     (bclk),
      .lrclk    (lrclk),
      .sdata    (sdata),
      .underrun (underrun)
   );

   always #5 clk = ~clk;

   int              n_tests = 0;
   int              n_fail  = 0;
   int              edge_n;
   int              slot_m;
   logic [SLEN-1:0] q[$];
   logic [SLEN-1:0] cur;
   logic            exp_ur;
   logic            accepted;
   logic            frame_start;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      edge_n      = 0;
      slot_m      = -1;
      cur         = '0;
      exp_ur      = 1'b0;
      accepted    = 1'b0;
      frame_start = 1'b0;
      q.delete();
   endtask

   // What happens at one clk edge: slot position from edge count, frame pop, push
   task automatic model_edge();
      logic rdy_pre;
      rdy_pre     = (q.size() < 2);
      edge_n++;
      exp_ur      = 1'b0;
      frame_start = 1'b0;
      if (edge_n % BITP == 0) begin
         slot_m = ((edge_n / BITP) - 1) % (2 * SLEN);
         if (slot_m == 0) begin
            frame_start = 1'b1;
            if (q.size() > 0) cur = q.pop_front();
            else begin
               cur    = '0;
               exp_ur = 1'b1;
            end
         end
      end
      accepted = bus.sample_vld && rdy_pre;
      if (accepted) q.push_back(bus.sample);
   endtask

   task automatic check_outputs();
      logic e_bclk, e_lr, e_sd;
      e_bclk = ((edge_n / CLK_DIV) % 2) == 1;
      if (slot_m < 0) begin
         e_lr = 1'b0;
         e_sd = 1'b0;
      end else begin
         e_lr = (slot_m >= SLEN - 1) && (slot_m <= 2 * SLEN - 2);
         e_sd = (slot_m < SLEN) ? cur[SLEN-1-slot_m] : cur[2*SLEN-1-slot_m];
      end
      check("bclk", 32'(bclk), 32'(e_bclk));
      check("lrclk", 32'(lrclk), 32'(e_lr));
      check("sdata", 32'(sdata), 32'(e_sd));
      check("underrun", 32'(underrun), 32'(exp_ur));
      check("sample_rdy", 32'(bus.sample_rdy), 32'(q.size() < 2));
   endtask

   task automatic check_reset();
      check("rst_bclk", 32'(bclk), 32'd0);
      check("rst_lrclk", 32'(lrclk), 32'd0);
      check("rst_sdata", 32'(sdata), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      check("rst_rdy", 32'(bus.sample_rdy), 32'd1);
   endtask

   // One clk: model the edge, check just after it, return at the next negedge
   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      if (rst_n) check_outputs();
      else check_reset();
      @(negedge clk);
   endtask

   task automatic run_idle(input int n);
      bus.sample_vld = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      int acc_in_frame;
      int starts_seen;
      logic [SLEN-1:0] next_val;

      model_reset();
      bus.sample     = 16'hBEEF;
      bus.sample_vld = 1'b1;

      // Reset held with a valid sample offered: nothing may be accepted
      for (int i = 0; i < 8; i++) cycle();
      bus.sample_vld = 1'b0;
      rst_n          = 1'b1;
      model_reset();

      // Single sample before the first frame start
      bus.sample     = 16'h8001;
      bus.sample_vld = 1'b1;
      cycle();
      run_idle(2 * FRAME + 16);

      // Back-to-back pushes fill the FIFO
      bus.sample     = 16'h1234;
      bus.sample_vld = 1'b1;
      cycle();
      bus.sample     = 16'hFFFF;
      cycle();
      run_idle(3 * FRAME);

      // Underrun frames, then a push mid-frame
      run_idle(2 * FRAME);
      for (int i = 0; i < FRAME && slot_m != 10; i++) cycle();
      check("wait_slot10", 32'(slot_m), 32'd10);
      bus.sample     = 16'hA5C3;
      bus.sample_vld = 1'b1;
      cycle();
      run_idle(2 * FRAME);

      // Random sparse traffic
      for (int i = 0; i < 6 * FRAME; i++) begin
         bus.sample     = SLEN'($urandom);
         bus.sample_vld = ($urandom_range(0, 199) == 0);
         cycle();
      end

      // Backpressure: valid held, sample increments on each acceptance
      next_val       = 16'h0100;
      bus.sample     = next_val;
      bus.sample_vld = 1'b1;
      acc_in_frame   = 0;
      starts_seen    = 0;
      for (int i = 0; i < 5 * FRAME; i++) begin
         cycle();
         if (frame_start) begin
            if (starts_seen >= 1) check("bp_accepts_per_frame", 32'(acc_in_frame), 32'd1);
            starts_seen++;
            acc_in_frame = 0;
         end
         if (accepted) begin
            acc_in_frame++;
            next_val   = next_val + SLEN'(1);
            bus.sample = next_val;
         end
      end

      // Mid-frame reset at slot 20 with the FIFO full
      for (int i = 0; i < 2 * FRAME && !(slot_m == 20 && q.size() == 2); i++) begin
         cycle();
         if (accepted) begin
            next_val   = next_val + SLEN'(1);
            bus.sample = next_val;
         end
      end
      check("wait_slot20_full", 32'(slot_m == 20 && q.size() == 2), 32'd1);
      bus.sample_vld = 1'b0;
      rst_n          = 1'b0;
      #1;
      check_reset();
      @(negedge clk);
      for (int i = 0; i < 3; i++) cycle();
      rst_n = 1'b1;
      model_reset();
      run_idle(2 * FRAME + 16);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
